// File: rtl/note_voice_ctrl.sv
// ============================================================================
// Module      : note_voice_ctrl
// Description : Debounced key-code to single-voice tone controller with
//               retrigger and stepped volume release envelope.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module note_voice_ctrl #(
    parameter int CLK_PER_MS      = 5000,
    parameter int DEBOUNCE_MS     = 10,
    parameter int RELEASE_STEP_MS = 4
) (
    input  logic        clk_5MHz,
    input  logic        rst,
    input  logic [4:0]  notecode,
    output logic        tone_en,
    output logic [14:0] half_period,
    output logic [4:0]  active_note,
    output logic [3:0]  volume
);

    localparam int c_TICK_W = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam int c_DEB_W  = $clog2(DEBOUNCE_MS + 1);
    localparam int c_STEP_W = $clog2(RELEASE_STEP_MS + 1);

    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(CLK_PER_MS - 1);
    localparam logic [c_DEB_W-1:0]  c_DEB_DONE  = c_DEB_W'(DEBOUNCE_MS);
    localparam logic [c_STEP_W-1:0] c_STEP_LAST = c_STEP_W'(RELEASE_STEP_MS - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PLAY    = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t              r_state;
    logic [c_TICK_W-1:0] r_tick_cnt;
    logic [4:0]          r_cand;
    logic [c_DEB_W-1:0]  r_stable_cnt;
    logic [c_STEP_W-1:0] r_step_cnt;
    logic [4:0]          r_active_note;
    logic [3:0]          r_volume;
    logic                r_tone_en;
    logic [14:0]         r_half_period;

    logic                w_tick;
    logic [4:0]          w_code;
    logic                w_stable;
    logic                w_press;

    assign w_tick   = (r_tick_cnt == c_TICK_LAST);
    assign w_code   = (notecode > 5'd21) ? 5'd0 : notecode;
    assign w_stable = (r_stable_cnt == c_DEB_DONE);
    assign w_press  = w_stable && (r_cand != 5'd0);

    function automatic logic [14:0] f_half_period(input logic [4:0] note);
        logic [14:0] hp;
        hp = 15'd0;
        case (note)
            5'd1:  hp = 15'd19111;
            5'd2:  hp = 15'd17026;
            5'd3:  hp = 15'd15169;
            5'd4:  hp = 15'd14317;
            5'd5:  hp = 15'd12755;
            5'd6:  hp = 15'd11364;
            5'd7:  hp = 15'd10124;
            5'd8:  hp = 15'd9555;
            5'd9:  hp = 15'd8513;
            5'd10: hp = 15'd7584;
            5'd11: hp = 15'd7158;
            5'd12: hp = 15'd6378;
            5'd13: hp = 15'd5682;
            5'd14: hp = 15'd5062;
            5'd15: hp = 15'd4778;
            5'd16: hp = 15'd4257;
            5'd17: hp = 15'd3792;
            5'd18: hp = 15'd3579;
            5'd19: hp = 15'd3189;
            5'd20: hp = 15'd2841;
            5'd21: hp = 15'd2531;
            default: hp = 15'd0;
        endcase
        return hp;
    endfunction

    always_ff @(posedge clk_5MHz or posedge rst) begin
        if (rst) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + c_TICK_W'(1);
        end
    end

    // A code change restarts the hold window; acceptance is lost at the same edge.
    always_ff @(posedge clk_5MHz or posedge rst) begin
        if (rst) begin
            r_cand       <= 5'd0;
            r_stable_cnt <= '0;
        end else if (w_code != r_cand) begin
            r_cand       <= w_code;
            r_stable_cnt <= '0;
        end else if (w_tick && !w_stable) begin
            r_stable_cnt <= r_stable_cnt + c_DEB_W'(1);
        end
    end

    always_ff @(posedge clk_5MHz or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_step_cnt    <= '0;
            r_active_note <= 5'd0;
            r_volume      <= 4'd0;
            r_tone_en     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_press) begin
                        r_state       <= S_PLAY;
                        r_active_note <= r_cand;
                        r_volume      <= 4'd15;
                        r_tone_en     <= 1'b1;
                    end
                end
                S_PLAY: begin
                    if (w_stable) begin
                        if (r_cand == 5'd0) begin
                            r_state    <= S_RELEASE;
                            r_step_cnt <= '0;
                        end else if (r_cand != r_active_note) begin
                            r_active_note <= r_cand;
                            r_volume      <= 4'd15;
                        end
                    end
                end
                S_RELEASE: begin
                    // A new key wins over a pending envelope step in the same cycle.
                    if (w_press) begin
                        r_state       <= S_PLAY;
                        r_active_note <= r_cand;
                        r_volume      <= 4'd15;
                    end else if (w_tick) begin
                        if (r_step_cnt == c_STEP_LAST) begin
                            r_step_cnt <= '0;
                            if (r_volume <= 4'd1) begin
                                r_state       <= S_IDLE;
                                r_volume      <= 4'd0;
                                r_active_note <= 5'd0;
                                r_tone_en     <= 1'b0;
                            end else begin
                                r_volume <= r_volume - 4'd1;
                            end
                        end else begin
                            r_step_cnt <= r_step_cnt + c_STEP_W'(1);
                        end
                    end
                end
                default: begin
                    r_state       <= S_IDLE;
                    r_active_note <= 5'd0;
                    r_volume      <= 4'd0;
                    r_tone_en     <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_5MHz or posedge rst) begin
        if (rst) begin
            r_half_period <= 15'd0;
        end else begin
            r_half_period <= f_half_period(r_active_note);
        end
    end

    assign tone_en     = r_tone_en;
    assign half_period = r_half_period;
    assign active_note = r_active_note;
    assign volume      = r_volume;

endmodule

`default_nettype wire
